// File: rtl/int_adder_pipe_if.sv
// ============================================================================
// Module      : int_adder_pipe_if
// Description : Operand/result handshake bundle for the int_adder_pipe block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface int_adder_pipe_if;
    logic        in_valid;
    logic        in_ready;
    logic        form;
    logic [1:0]  precision;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] C;
    logic [31:0] D;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Y1;
    logic [31:0] Y2;

    modport master (
        output in_valid, form, precision, A, B, C, D, out_ready,
        input  in_ready, out_valid, Y1, Y2
    );

    modport slave (
        input  in_valid, form, precision, A, B, C, D, out_ready,
        output in_ready, out_valid, Y1, Y2
    );
endinterface

`default_nettype wire

// File: rtl/int_adder_pipe.sv
// ============================================================================
// Module      : int_adder_pipe
// Description : Two-stage SIMD integer adder (8/16/32-bit lanes or one 64-bit
//               add); optional lane saturation under macro INT_ADDER_SAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module int_adder_pipe (
    input  logic            clk,
    input  logic            rst,
    int_adder_pipe_if.slave bus
);

    localparam logic [1:0] c_PREC_8  = 2'd0;
    localparam logic [1:0] c_PREC_16 = 2'd1;
    localparam logic [1:0] c_PREC_32 = 2'd2;

    logic        w_adv;
    logic        w_accept;

    logic        r_s1_valid;
    logic        r_s1_form;
    logic [1:0]  r_s1_prec;
    logic [31:0] r_s1_a;
    logic [31:0] r_s1_b;
    logic [31:0] r_s1_c;
    logic [31:0] r_s1_d;

    logic        r_out_valid;
    logic [31:0] r_y1;
    logic [31:0] r_y2;

    logic [2:0][31:0] w_lane_y1;
    logic [2:0][31:0] w_lane_y2;
    logic [63:0]      w_wide;
    logic [31:0]      w_y1;
    logic [31:0]      w_y2;

    // Stage 1 may refill in the same edge that stage 2 drains.
    assign w_adv        = !r_out_valid || bus.out_ready;
    assign bus.in_ready = !r_s1_valid || w_adv;
    assign w_accept     = bus.in_valid && bus.in_ready;

    assign bus.out_valid = r_out_valid;
    assign bus.Y1        = r_y1;
    assign bus.Y2        = r_y2;

    // One lane array per width; the mode mux below picks the active one.
    for (genvar gw = 0; gw < 3; gw++) begin : g_width
        localparam int W = 8 << gw;
        for (genvar gl = 0; gl < 32 / W; gl++) begin : g_lane
            logic [W-1:0] w_a, w_b, w_c, w_d, w_p1, w_p2;
            logic [W+1:0] w_tri;

            assign w_a   = r_s1_a[gl*W +: W];
            assign w_b   = r_s1_b[gl*W +: W];
            assign w_c   = r_s1_c[gl*W +: W];
            assign w_d   = r_s1_d[gl*W +: W];
            assign w_tri = {2'b00, w_a} + {2'b00, w_b} + {2'b00, w_c};
`ifdef INT_ADDER_SAT_EN
            logic [W:0] w_s1, w_s2;
            assign w_s1 = {1'b0, w_a} + {1'b0, w_c};
            assign w_s2 = {1'b0, w_b} + {1'b0, w_d};
            assign w_p1 = w_s1[W] ? {W{1'b1}} : w_s1[W-1:0];
            assign w_p2 = w_s2[W] ? {W{1'b1}} : w_s2[W-1:0];
`else
            assign w_p1 = w_a + w_c;
            assign w_p2 = w_b + w_d;
`endif
            // Widening form: the 2w-bit sum splits with its high half in Y1.
            assign w_lane_y1[gw][gl*W +: W] = r_s1_form ? {{(W-2){1'b0}}, w_tri[W+1:W]} : w_p1;
            assign w_lane_y2[gw][gl*W +: W] = r_s1_form ? w_tri[W-1:0] : w_p2;
        end
    end

    assign w_wide = {r_s1_a, r_s1_b} + {r_s1_c, r_s1_d};

    always_comb begin
        w_y1 = w_wide[63:32];
        w_y2 = w_wide[31:0];
        case (r_s1_prec)
            c_PREC_8:  begin w_y1 = w_lane_y1[0]; w_y2 = w_lane_y2[0]; end
            c_PREC_16: begin w_y1 = w_lane_y1[1]; w_y2 = w_lane_y2[1]; end
            c_PREC_32: begin w_y1 = w_lane_y1[2]; w_y2 = w_lane_y2[2]; end
            default:   ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
        end else if (w_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    // Operand payload needs no reset; it is qualified by r_s1_valid.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_s1_form <= bus.form;
            r_s1_prec <= bus.precision;
            r_s1_a    <= bus.A;
            r_s1_b    <= bus.B;
            r_s1_c    <= bus.C;
            r_s1_d    <= bus.D;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_y1        <= '0;
            r_y2        <= '0;
        end else if (w_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_y1 <= w_y1;
                r_y2 <= w_y2;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_int_adder_pipe.sv
// ============================================================================
// Module      : tb_int_adder_pipe
// Description : Self-checking bench for int_adder_pipe with a queue-based
//               reference model; honours INT_ADDER_SAT_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_int_adder_pipe;

    typedef struct {
        logic        form;
        logic [1:0]  prec;
        logic [31:0] a, b, c, d;
    } beat_t;

    typedef struct {
        logic [31:0] y1, y2;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int_adder_pipe_if ifc ();

    int_adder_pipe dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    always #5 clk = ~clk;

    beat_t send_q[$];
    exp_t  exp_q[$];
    int    acc_edges[$];
    int    cons_edges[$];
    int    n_assert = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    int    gap      = 0;
    bit    rand_ready = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: lane arithmetic straight from the mode rules.
    function automatic logic [63:0] model(input beat_t bt);
        logic [63:0] y1, y2, mask, av, bv, cv, dv, s1, s2;
        int w;
        if (bt.prec == 2'd3) return {bt.a, bt.b} + {bt.c, bt.d};
        w    = 8 << bt.prec;
        mask = (64'd1 << w) - 64'd1;
        y1   = '0;
        y2   = '0;
        for (int i = 0; i < 32 / w; i++) begin
            av = ({32'd0, bt.a} >> (i * w)) & mask;
            bv = ({32'd0, bt.b} >> (i * w)) & mask;
            cv = ({32'd0, bt.c} >> (i * w)) & mask;
            dv = ({32'd0, bt.d} >> (i * w)) & mask;
            if (bt.form == 1'b0) begin
                s1 = av + cv;
                s2 = bv + dv;
`ifdef INT_ADDER_SAT_EN
                if (s1 > mask) s1 = mask;
                if (s2 > mask) s2 = mask;
`endif
                y1 |= (s1 & mask) << (i * w);
                y2 |= (s2 & mask) << (i * w);
            end else begin
                s1 = av + bv + cv;
                y1 |= (s1 >> w) << (i * w);
                y2 |= (s1 & mask) << (i * w);
            end
        end
        return {y1[31:0], y2[31:0]};
    endfunction

    function automatic beat_t rand_beat();
        beat_t bt;
        bt.form = 1'($urandom_range(1));
        bt.prec = 2'($urandom_range(3));
        bt.a = $urandom;
        bt.b = $urandom;
        bt.c = $urandom;
        bt.d = $urandom;
        return bt;
    endfunction

    task automatic drive();
        if (rand_ready) ifc.out_ready = 1'($urandom_range(1));
        if (send_q.size() > 0 && $urandom_range(99) >= gap) begin
            ifc.in_valid  = 1'b1;
            ifc.form      = send_q[0].form;
            ifc.precision = send_q[0].prec;
            ifc.A = send_q[0].a;
            ifc.B = send_q[0].b;
            ifc.C = send_q[0].c;
            ifc.D = send_q[0].d;
        end else begin
            ifc.in_valid  = 1'b0;
            ifc.form      = 1'($urandom_range(1));
            ifc.precision = 2'($urandom_range(3));
            ifc.A = $urandom;
            ifc.B = $urandom;
            ifc.C = $urandom;
            ifc.D = $urandom;
        end
    endtask

    // One clock: drive, check visible state against the model, then advance.
    task automatic cycle();
        bit          acc, cons, exp_ir, exp_ov;
        exp_t        e;
        logic [63:0] m;
        drive();
        #1;
        exp_ir = !(exp_q.size() == 2 && !ifc.out_ready);
        exp_ov = (exp_q.size() >= 2) || (exp_q.size() == 1 && exp_q[0].acc != cyc - 1);
        check("in_ready", 64'(ifc.in_ready), 64'(exp_ir));
        check("out_valid", 64'(ifc.out_valid), 64'(exp_ov));
        acc  = !rst && ifc.in_valid && ifc.in_ready;
        cons = !rst && ifc.out_valid && ifc.out_ready;
        if (cons) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 64'(ifc.out_valid), 64'd0);
            end else begin
                check("Y1", 64'(ifc.Y1), 64'(exp_q[0].y1));
                check("Y2", 64'(ifc.Y2), 64'(exp_q[0].y2));
                void'(exp_q.pop_front());
            end
            cons_edges.push_back(cyc);
        end
        if (acc) begin
            m     = model(send_q[0]);
            e.y1  = m[63:32];
            e.y2  = m[31:0];
            e.acc = cyc;
            exp_q.push_back(e);
            acc_edges.push_back(cyc);
            void'(send_q.pop_front());
        end
        if (rst) exp_q.delete();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_until_empty(input int budget);
        int b = budget;
        while ((send_q.size() > 0 || exp_q.size() > 0) && b > 0) begin
            cycle();
            b--;
        end
        check("drain_done", 64'(send_q.size() + exp_q.size()), 64'd0);
    endtask

    task automatic vec(input string tag, input logic f, input logic [1:0] p,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic [31:0] d,
                       input logic [31:0] e1, input logic [31:0] e2);
        beat_t bt;
        int    b_left = 8;
        logic [31:0] h1, h2;
        bt.form = f; bt.prec = p; bt.a = a; bt.b = b; bt.c = c; bt.d = d;
        rand_ready    = 1'b0;
        ifc.out_ready = 1'b0;
        send_q.push_back(bt);
        while (!ifc.out_valid && b_left > 0) begin
            cycle();
            b_left--;
        end
        check({tag, "_valid"}, 64'(ifc.out_valid), 64'd1);
        check({tag, "_Y1"}, 64'(ifc.Y1), 64'(e1));
        check({tag, "_Y2"}, 64'(ifc.Y2), 64'(e2));
        h1 = ifc.Y1;
        h2 = ifc.Y2;
        cycle();
        cycle();
        check({tag, "_hold_Y1"}, 64'(ifc.Y1), 64'(h1));
        check({tag, "_hold_Y2"}, 64'(ifc.Y2), 64'(h2));
        ifc.out_ready = 1'b1;
        cycle();
    endtask

    initial begin
        logic [31:0] h1, h2;
        bit          held;
        int          b_left;

        rst = 1'b1;
        ifc.in_valid = 1'b0; ifc.out_ready = 1'b0; ifc.form = 1'b0; ifc.precision = 2'd0;
        ifc.A = '0; ifc.B = '0; ifc.C = '0; ifc.D = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(ifc.out_valid), 64'd0);
        check("rst_Y1", 64'(ifc.Y1), 64'd0);
        check("rst_Y2", 64'(ifc.Y2), 64'd0);
        rst = 1'b0;
        #1;
        check("rst_in_ready", 64'(ifc.in_ready), 64'd1);

        // Directed lane vectors
`ifdef INT_ADDER_SAT_EN
        vec("p8_pair", 1'b0, 2'd0, 32'h01FF7F10, 32'h0, 32'h01018120, 32'h0, 32'h02FFFF30, 32'h0);
`else
        vec("p8_pair", 1'b0, 2'd0, 32'h01FF7F10, 32'h0, 32'h01018120, 32'h0, 32'h02000030, 32'h0);
`endif
        vec("p16_wide", 1'b1, 2'd1, 32'hFFFF0001, 32'hFFFF0002, 32'hFFFF0003, 32'h0,
            32'h00020000, 32'hFFFD0006);
        vec("p64", 1'b0, 2'd3, 32'h00000000, 32'hFFFFFFFF, 32'h0, 32'h1, 32'h00000001, 32'h0);

        // Eight back-to-back beats at full throughput
        ifc.out_ready = 1'b1;
        gap = 0;
        acc_edges.delete();
        cons_edges.delete();
        for (int i = 0; i < 8; i++) send_q.push_back(rand_beat());
        run_until_empty(40);
        check("b2b_count", 64'(cons_edges.size()), 64'd8);
        if (cons_edges.size() > 0 && acc_edges.size() > 0)
            check("b2b_latency", 64'(cons_edges[0]), 64'(acc_edges[0] + 2));
        for (int i = 1; i < cons_edges.size(); i++)
            check("b2b_rate", 64'(cons_edges[i]), 64'(cons_edges[0] + i));

        // Back-pressure: three beats against a stalled output
        ifc.out_ready = 1'b0;
        acc_edges.delete();
        held = 1'b0;
        h1 = '0;
        h2 = '0;
        for (int i = 0; i < 3; i++) send_q.push_back(rand_beat());
        for (int i = 0; i < 5; i++) begin
            cycle();
            if (ifc.out_valid) begin
                if (!held) begin
                    held = 1'b1;
                    h1 = ifc.Y1;
                    h2 = ifc.Y2;
                end else begin
                    check("bp_hold_Y1", 64'(ifc.Y1), 64'(h1));
                    check("bp_hold_Y2", 64'(ifc.Y2), 64'(h2));
                end
            end
        end
        #1;
        check("bp_accepts", 64'(acc_edges.size()), 64'd2);
        check("bp_in_ready", 64'(ifc.in_ready), 64'd0);
        ifc.out_ready = 1'b1;
        run_until_empty(20);

        // Random soak with mixed modes, bubbles and back-pressure
        rand_ready = 1'b1;
        gap = 30;
        for (int i = 0; i < 60; i++) send_q.push_back(rand_beat());
        run_until_empty(800);
        rand_ready = 1'b0;
        gap = 0;

        // Mid-flight reset with both stages full
        ifc.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_q.push_back(rand_beat());
        b_left = 10;
        while (exp_q.size() < 2 && b_left > 0) begin
            cycle();
            b_left--;
        end
        check("full_before_rst", 64'(exp_q.size()), 64'd2);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("mrst_out_valid", 64'(ifc.out_valid), 64'd0);
        check("mrst_Y1", 64'(ifc.Y1), 64'd0);
        check("mrst_Y2", 64'(ifc.Y2), 64'd0);
        ifc.out_ready = 1'b1;
        cons_edges.delete();
        for (int i = 0; i < 8; i++) cycle();
        check("mrst_delivered", 64'(cons_edges.size()), 64'd1);
        check("mrst_empty", 64'(send_q.size() + exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
